// File: rtl/p_seq_acc_pkg.sv
// Shared types for the perceptron datapath: data configuration, accumulator
// FSM states and the accumulator width rule.
package p_seq_acc_pkg;

  typedef enum logic [1:0] {INT, FXP, FP, BOOL} dtype_t;

  typedef struct packed {
    dtype_t     dtype;
    logic [7:0] prec;
    logic [7:0] frac;
  } dconf_t;

  localparam dconf_t DEF_DCONF = '{dtype: INT, prec: 8'd8, frac: 8'd0};

  typedef enum logic [1:0] {IDLE, ACC, DONE} acc_state_t;

  // Wide enough that a full packet of full-scale operands plus bias never wraps.
  function automatic int acc_width(input int prec, input int lanes, input int beats_w);
    return prec + $clog2(lanes + 1) + beats_w;
  endfunction

endpackage

// File: rtl/p_seq_acc_fin.sv
// Finalisation of a closed packet sum: arithmetic shift, round-to-nearest-even
// (FXP only), saturation to the output precision and exception flags.
module p_seq_acc_fin
  import p_seq_acc_pkg::*;
#(
  parameter int     ACC_W = 14,
  parameter int     SHIFT = 0,
  parameter dconf_t CONF  = DEF_DCONF,
  localparam int    P     = int'(CONF.prec)
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [P-1:0]     res,
  output logic                    ovf,
  output logic                    udf,
  output logic                    rounded
);

  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-P+2){1'b0}}, {(P-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = ~MAXV;

  // One extra bit so a rounding carry out of the shifted value is still visible.
  logic signed [ACC_W:0] q;
  logic signed [ACC_W:0] qr;
  logic                  inc;
  logic                  any_disc;

  if (SHIFT == 0) begin : g_noshift
    assign q        = {acc[ACC_W-1], acc};
    assign inc      = 1'b0;
    assign any_disc = 1'b0;
  end else begin : g_shift
    localparam logic [SHIFT-1:0] HALF = SHIFT'(1) << (SHIFT - 1);
    logic [SHIFT-1:0] disc;
    assign disc     = acc[SHIFT-1:0];
    assign q        = $signed({acc[ACC_W-1], acc}) >>> SHIFT;
    assign inc      = (CONF.dtype == FXP) && ((disc > HALF) || ((disc == HALF) && q[0]));
    assign any_disc = |disc;
  end

  assign qr = q + $signed({{ACC_W{1'b0}}, inc});

  always_comb begin
    res     = '0;
    ovf     = 1'b0;
    udf     = 1'b0;
    rounded = 1'b0;
    case (CONF.dtype)
      BOOL: res[0] = acc[0];
      FXP: begin
        rounded = any_disc;
        if (qr > MAXV) begin
          res = MAXV[P-1:0];
          ovf = 1'b1;
        end else if (qr < MINV) begin
          res = MINV[P-1:0];
          udf = 1'b1;
        end else begin
          res = qr[P-1:0];
        end
      end
      default: begin
        if (qr > MAXV) begin
          res = MAXV[P-1:0];
          ovf = 1'b1;
        end else if (qr < MINV) begin
          res = MINV[P-1:0];
          ovf = 1'b1;
        end else begin
          res = qr[P-1:0];
        end
      end
    endcase
  end

endmodule

// File: rtl/p_seq_acc.sv
// Multi-beat streaming accumulator: bias-preloaded packet sum over LANES
// operands per beat, finalised into a held valid/ready result with flags.
module p_seq_acc
  import p_seq_acc_pkg::*;
#(
  parameter int     LANES   = 8,
  parameter dconf_t CONF    = DEF_DCONF,
  parameter int     BEATS_W = 8,
  parameter int     SHIFT   = 0,
  localparam int    P       = int'(CONF.prec)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [LANES-1:0][P-1:0] in,
  input  logic [P-1:0]            bias,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [P-1:0]            out,
  output logic                    ovf,
  output logic                    udf,
  output logic                    rounded,
  output logic [BEATS_W-1:0]      beats,
  output acc_state_t              dbg_state
);

  localparam int ACC_W = acc_width(P, LANES, BEATS_W);
  localparam logic [BEATS_W-1:0] CNT_MAX = '1;

  if (CONF.dtype == FP) begin : g_fp_unsupported
    $error("p_seq_acc: FP data type is not supported");
  end

  // Handshakes: a beat moves when in_valid & in_ready, a result moves when
  // out_valid & out_ready; neither valid depends combinationally on its ready.
  acc_state_t                state, state_nxt;
  logic signed [ACC_W-1:0]   acc, acc_sum, beat_sum, bias_ext, base;
  logic        [BEATS_W-1:0] cnt, cnt_inc;
  logic                      fire, first, close;
  logic        [P-1:0]       fin_res;
  logic                      fin_ovf, fin_udf, fin_rnd;

  assign out_valid = (state == DONE);
  assign in_ready  = (state != DONE) | out_ready;
  assign fire      = in_valid & in_ready;
  assign first     = (state != ACC);
  assign dbg_state = state;

  // BOOL packets are an OR-reduction kept in bit 0 of the accumulator.
  always_comb begin
    beat_sum = '0;
    bias_ext = '0;
    if (CONF.dtype == BOOL) begin
      for (int i = 0; i < LANES; i++) beat_sum[0] = beat_sum[0] | in[i][0];
      bias_ext[0] = |bias;
    end else begin
      for (int i = 0; i < LANES; i++) beat_sum = beat_sum + ACC_W'($signed(in[i]));
      bias_ext = ACC_W'($signed(bias));
    end
  end

  assign base    = first ? bias_ext : acc;
  assign acc_sum = (CONF.dtype == BOOL) ? (base | beat_sum) : (base + beat_sum);
  assign cnt_inc = first ? BEATS_W'(1) : (cnt + 1'b1);
  assign close   = fire & (in_last | (cnt_inc == CNT_MAX));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (fire) state_nxt = close ? DONE : ACC;
      ACC:  if (fire) state_nxt = close ? DONE : ACC;
      DONE: begin
        if (fire)           state_nxt = close ? DONE : ACC;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  p_seq_acc_fin #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .CONF  (CONF)
  ) u_fin (
    .acc     (acc_sum),
    .res     (fin_res),
    .ovf     (fin_ovf),
    .udf     (fin_udf),
    .rounded (fin_rnd)
  );

  // The result register only loads on a closing beat, so it holds while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      cnt     <= '0;
      out     <= '0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
      rounded <= 1'b0;
      beats   <= '0;
    end else begin
      if (fire) begin
        acc <= acc_sum;
        cnt <= cnt_inc;
      end
      if (close) begin
        out     <= fin_res;
        ovf     <= fin_ovf;
        udf     <= fin_udf;
        rounded <= fin_rnd;
        beats   <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_p_seq_acc.sv
// Bench for p_seq_acc: INT, FXP and BOOL instances share one beat stream and
// are checked against a behavioural model through per-instance expected queues.
module tb_p_seq_acc;
  import p_seq_acc_pkg::*;

  localparam dconf_t CF_INT  = '{dtype: INT,  prec: 8'd8, frac: 8'd0};
  localparam dconf_t CF_FXP  = '{dtype: FXP,  prec: 8'd8, frac: 8'd4};
  localparam dconf_t CF_BOOL = '{dtype: BOOL, prec: 8'd8, frac: 8'd0};

  logic            clk, reset, in_valid, in_last, out_ready;
  logic [3:0][7:0] in_d;
  logic [7:0]      bias;

  logic       ov_int, rdy_int, ovf_int, udf_int, rnd_int;
  logic       ov_fxp, rdy_fxp, ovf_fxp, udf_fxp, rnd_fxp;
  logic       ov_bool, rdy_bool, ovf_bool, udf_bool, rnd_bool;
  logic [7:0] out_int, out_fxp, out_bool;
  logic [2:0] beats_int, beats_fxp, beats_bool;
  acc_state_t st_int, st_fxp, st_bool;

  p_seq_acc #(.LANES(4), .CONF(CF_INT), .BEATS_W(3), .SHIFT(0)) u_int (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_int), .in_last(in_last),
    .in(in_d), .bias(bias), .out_valid(ov_int), .out_ready(out_ready), .out(out_int),
    .ovf(ovf_int), .udf(udf_int), .rounded(rnd_int), .beats(beats_int), .dbg_state(st_int)
  );

  p_seq_acc #(.LANES(4), .CONF(CF_FXP), .BEATS_W(3), .SHIFT(1)) u_fxp (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_fxp), .in_last(in_last),
    .in(in_d), .bias(bias), .out_valid(ov_fxp), .out_ready(out_ready), .out(out_fxp),
    .ovf(ovf_fxp), .udf(udf_fxp), .rounded(rnd_fxp), .beats(beats_fxp), .dbg_state(st_fxp)
  );

  p_seq_acc #(.LANES(4), .CONF(CF_BOOL), .BEATS_W(3), .SHIFT(1)) u_bool (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_bool), .in_last(in_last),
    .in(in_d), .bias(bias), .out_valid(ov_bool), .out_ready(out_ready), .out(out_bool),
    .ovf(ovf_bool), .udf(udf_bool), .rounded(rnd_bool), .beats(beats_bool), .dbg_state(st_bool)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard state: {out[7:0], ovf, udf, rounded, beats[2:0]}
  logic [13:0] exp_int_q[$];
  logic [13:0] exp_fxp_q[$];
  logic [13:0] exp_bool_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  longint macc;
  logic   mbool;
  int     mcnt;
  bit     mfirst = 1'b1;
  bit     rnd    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference finalisation: {out, ovf, udf, rounded}
  function automatic logic [10:0] fin_int(input longint a);
    if (a > 127)  return {8'h7f, 3'b100};
    if (a < -128) return {8'h80, 3'b100};
    return {a[7:0], 3'b000};
  endfunction

  function automatic logic [10:0] fin_fxp(input longint a);
    longint q;
    logic   r;
    q = a >>> 1;
    r = a[0];
    if (r && q[0]) q = q + 1;
    if (q > 127)  return {8'h7f, 2'b10, r};
    if (q < -128) return {8'h80, 2'b01, r};
    return {q[7:0], 2'b00, r};
  endfunction

  task automatic model_beat(input logic [3:0][7:0] d, input logic last, input logic [7:0] b,
                            output logic closed);
    longint s;
    logic   bo;
    s  = 0;
    bo = 1'b0;
    for (int l = 0; l < 4; l++) begin
      s  = s + longint'($signed(d[l]));
      bo = bo | d[l][0];
    end
    if (mfirst) begin
      macc   = longint'($signed(b)) + s;
      mbool  = (|b) | bo;
      mcnt   = 1;
      mfirst = 1'b0;
    end else begin
      macc  = macc + s;
      mbool = mbool | bo;
      mcnt  = mcnt + 1;
    end
    closed = last || (mcnt == 7);
    if (closed) begin
      exp_int_q.push_back({fin_int(macc), 3'(mcnt)});
      exp_fxp_q.push_back({fin_fxp(macc), 3'(mcnt)});
      exp_bool_q.push_back({7'd0, mbool, 3'b000, 3'(mcnt)});
      mfirst = 1'b1;
    end
  endtask

  // Driver: present one beat, wait (bounded) for acceptance, then update the model.
  task automatic send_beat(input logic [3:0][7:0] d, input logic last, input logic [7:0] b);
    logic ok, closed;
    in_d     = d;
    in_last  = last;
    bias     = b;
    in_valid = 1'b1;
    if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    ok = 1'b0;
    for (int w = 0; w < 50 && !ok; w++) begin
      @(negedge clk);
      if (rdy_int) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    model_beat(d, last, b, closed);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (closed) check("latency", {ov_int, ov_fxp, ov_bool}, 3'b111);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_int"},  {ov_int,  out_int,  ovf_int,  udf_int,  rnd_int,  beats_int,  rdy_int},  16'h0001);
    check({tag, "_fxp"},  {ov_fxp,  out_fxp,  ovf_fxp,  udf_fxp,  rnd_fxp,  beats_fxp,  rdy_fxp},  16'h0001);
    check({tag, "_bool"}, {ov_bool, out_bool, ovf_bool, udf_bool, rnd_bool, beats_bool, rdy_bool}, 16'h0001);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard compare at every result transfer
  always @(negedge clk) begin
    if (!reset && ov_int && out_ready) begin
      if (exp_int_q.size() == 0) check("int_extra", 32'd1, 32'd0);
      else check("int_res", {out_int, ovf_int, udf_int, rnd_int, beats_int}, exp_int_q.pop_front());
    end
    if (!reset && ov_fxp && out_ready) begin
      if (exp_fxp_q.size() == 0) check("fxp_extra", 32'd1, 32'd0);
      else check("fxp_res", {out_fxp, ovf_fxp, udf_fxp, rnd_fxp, beats_fxp}, exp_fxp_q.pop_front());
    end
    if (!reset && ov_bool && out_ready) begin
      if (exp_bool_q.size() == 0) check("bool_extra", 32'd1, 32'd0);
      else check("bool_res", {out_bool, ovf_bool, udf_bool, rnd_bool, beats_bool}, exp_bool_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][7:0] d;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_d      = '0;
    bias      = '0;
    out_ready = 1'b1;
    idle_cycles(3);
    reset = 1'b0;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;

    // Two-beat INT reference packet: 1 + 10 + 26 = 37
    send_beat({8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, 8'd1);
    send_beat({8'd8, 8'd7, 8'd6, 8'd5}, 1'b1, 8'd99);
    // Saturation both ways
    send_beat({8'd100, 8'd100, 8'd100, 8'd100}, 1'b1, 8'd0);
    send_beat({-8'sd100, -8'sd100, -8'sd100, -8'sd100}, 1'b1, 8'd0);
    // FXP rounding ties and negative saturation
    send_beat({8'd4, 8'd4, 8'd4, 8'd4}, 1'b1, 8'd3);
    send_beat({8'd4, 8'd4, 8'd4, 8'd4}, 1'b1, 8'd2);
    send_beat({8'h80, 8'h80, 8'h80, 8'h80}, 1'b1, 8'h80);
    send_beat({8'd0, 8'd0, 8'd0, 8'd0}, 1'b1, 8'd0);
    idle_cycles(2);

    // Backpressure: result held and input stalled until out_ready
    out_ready = 1'b0;
    send_beat({8'd4, 8'd3, 8'd2, 8'd1}, 1'b1, 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", rdy_int, 1'b0);
      check("bp_hold", {ov_int, out_int}, {1'b1, 8'd10});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_beat({8'd1, 8'd1, 8'd1, 8'd1}, 1'b1, 8'd5);
    idle_cycles(2);

    // Forced close after 7 beats; the 8th opens a new packet with its own bias
    for (int k = 0; k < 8; k++)
      send_beat({8'd1, 8'd2, 8'd1, 8'd2}, 1'b0, (k == 7) ? 8'd20 : 8'd10);
    send_beat({8'd3, 8'd3, 8'd3, 8'd3}, 1'b1, 8'd77);
    idle_cycles(3);

    // Reset in the middle of a packet discards it
    send_beat({8'd9, 8'd9, 8'd9, 8'd9}, 1'b0, 8'd1);
    in_d     = {8'd5, 8'd5, 8'd5, 8'd5};
    in_last  = 1'b0;
    in_valid = 1'b1;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    mfirst   = 1'b1;
    check_zero("mid_reset");
    send_beat({8'd2, 8'd2, 8'd2, 8'd2}, 1'b1, 8'd1);
    idle_cycles(2);

    // Random packets with gaps, random backpressure and forced closes
    rnd = 1'b1;
    for (int p = 0; p < 25; p++) begin
      int n;
      n = $urandom_range(1, 9);
      for (int k = 0; k < n; k++) begin
        for (int l = 0; l < 4; l++) d[l] = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) idle_cycles(1);
        send_beat(d, k == n - 1, 8'($urandom_range(0, 255)));
      end
    end
    rnd       = 1'b0;
    out_ready = 1'b1;
    idle_cycles(5);
    check("drain_int",  exp_int_q.size(),  32'd0);
    check("drain_fxp",  exp_fxp_q.size(),  32'd0);
    check("drain_bool", exp_bool_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
